// File: rtl/video_pkg.sv
// Shared constants and state encoding for the NTSC field capture path.
package video_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_DECIM  = 2;
    localparam int BUF_W    = 320;
    localparam int BUF_H    = 240;
    localparam int RGB_W    = 12;
    localparam int ADDR_W   = 17;
    localparam int COL_W    = 9;
    localparam int ROW_W    = 8;
    localparam int CNT_W    = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } cap_state_e;
endpackage

// File: rtl/capture_addr_gen.sv
// Buffer write address generator: running row base plus column counter.
module capture_addr_gen
    import video_pkg::*;
#(
    parameter int ROW_STRIDE = BUF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              inc_col_i,
    input  logic              next_row_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [COL_W-1:0]  col_o
);
    logic [ADDR_W-1:0] base_q, base_d;
    logic [COL_W-1:0]  col_q, col_d;

    // Row base advances by a constant stride, so no multiplier is needed.
    always_comb begin
        base_d = base_q;
        col_d  = col_q;
        if (clear_i) begin
            base_d = '0;
            col_d  = '0;
        end else if (next_row_i) begin
            base_d = base_q + ADDR_W'(ROW_STRIDE);
            col_d  = '0;
        end else if (inc_col_i) begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            col_q  <= '0;
        end else begin
            base_q <= base_d;
            col_q  <= col_d;
        end
    end

    assign addr_o = base_q + ADDR_W'(col_q);
    assign col_o  = col_q;
endmodule

// File: rtl/ntsc_capture.sv
// Captures one decimated NTSC field into ntsc_buf, with a freeze handshake
// so the downstream mapper can hold a stable source frame.
module ntsc_capture #(
    parameter int H_ACTIVE      = 640,
    parameter int H_DECIM       = 2,
    parameter int BUF_W         = 320,
    parameter int BUF_H         = 240,
    parameter bit CAPTURE_FIELD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_valid,
    input  logic [11:0] rgb_in,
    input  logic        sol,
    input  logic        sof,
    input  logic        field,
    input  logic        capture_en,
    output logic        ntsc_in_wr,
    output logic [16:0] ntsc_in_addr,
    output logic [11:0] pixel_out,
    output logic        frame_done,
    output logic        frozen
);
    import video_pkg::cap_state_e;
    import video_pkg::IDLE;
    import video_pkg::WAIT_LINE;
    import video_pkg::CAPTURE;
    import video_pkg::DONE;
    import video_pkg::ADDR_W;
    import video_pkg::COL_W;
    import video_pkg::ROW_W;
    import video_pkg::CNT_W;

    localparam int PH_W = (H_DECIM > 1) ? $clog2(H_DECIM) : 1;

    cap_state_e        state_q;
    logic [ROW_W-1:0]  row_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PH_W-1:0]   phase_q;
    logic              wr_q, done_q, frozen_q;
    logic [16:0]       addr_q;
    logic [11:0]       pix_q;

    logic              start, accept, line_full, line_close, last_row, next_row;
    logic [ADDR_W-1:0] gen_addr;
    logic [COL_W-1:0]  gen_col;

    // Field start is only honoured outside DONE; a strobe there is ignored.
    assign start      = sof && (field == CAPTURE_FIELD) && capture_en && (state_q != DONE);
    assign accept     = (state_q == CAPTURE) && !sof && !sol && pixel_valid &&
                        (cnt_q < CNT_W'(H_ACTIVE)) && (phase_q == '0);
    assign line_full  = accept && (gen_col == COL_W'(BUF_W - 1));
    assign line_close = ((state_q == CAPTURE) && !sof && sol) || line_full;
    assign last_row   = (row_q == ROW_W'(BUF_H - 1));
    assign next_row   = line_close && !last_row;

    capture_addr_gen #(
        .ROW_STRIDE(BUF_W)
    ) u_addr (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (start),
        .inc_col_i (accept),
        .next_row_i(next_row),
        .addr_o    (gen_addr),
        .col_o     (gen_col)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            pix_q    <= '0;
            done_q   <= 1'b0;
            frozen_q <= 1'b1;
        end else begin
            wr_q   <= accept;
            done_q <= 1'b0;
            if (accept) begin
                addr_q <= gen_addr;
                pix_q  <= rgb_in;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= WAIT_LINE;
                        row_q    <= '0;
                        frozen_q <= 1'b0;
                    end
                end
                WAIT_LINE, CAPTURE: begin
                    // A new sof abandons the field and is re-evaluated as a start.
                    if (sof) begin
                        row_q <= '0;
                        if (start) begin
                            state_q  <= WAIT_LINE;
                            frozen_q <= 1'b0;
                        end else begin
                            state_q  <= IDLE;
                            frozen_q <= 1'b1;
                        end
                    end else if (line_close) begin
                        cnt_q   <= '0;
                        phase_q <= '0;
                        if (last_row) begin
                            state_q  <= DONE;
                            frozen_q <= 1'b1;
                        end else begin
                            row_q   <= row_q + ROW_W'(1);
                            state_q <= sol ? CAPTURE : WAIT_LINE;
                        end
                    end else if (state_q == WAIT_LINE) begin
                        if (sol) begin
                            state_q <= CAPTURE;
                            cnt_q   <= '0;
                            phase_q <= '0;
                        end
                    end else if (pixel_valid) begin
                        if (cnt_q < CNT_W'(H_ACTIVE)) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        phase_q <= (phase_q == PH_W'(H_DECIM - 1)) ? '0 : phase_q + PH_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    frozen_q <= 1'b1;
                end
            endcase
        end
    end

    assign ntsc_in_wr   = wr_q;
    assign ntsc_in_addr = addr_q;
    assign pixel_out    = pix_q;
    assign frame_done   = done_q;
    assign frozen       = frozen_q;
endmodule

// File: tb/tb_ntsc_capture.sv
// Scoreboard bench for ntsc_capture: directed line/field stimulus, expected
// writes queued at issue time and checked by an independent monitor.
module tb_ntsc_capture;
    logic        clk = 1'b0;
    logic        reset, pixel_valid, sol, sof, field, capture_en;
    logic [11:0] rgb_in;
    logic        ntsc_in_wr, frame_done, frozen;
    logic [16:0] ntsc_in_addr;
    logic [11:0] pixel_out;

    typedef struct packed {
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  done_cnt = 0;
    bit  prev_wr = 1'b0;

    ntsc_capture dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .rgb_in      (rgb_in),
        .sol         (sol),
        .sof         (sof),
        .field       (field),
        .capture_en  (capture_en),
        .ntsc_in_wr  (ntsc_in_wr),
        .ntsc_in_addr(ntsc_in_addr),
        .pixel_out   (pixel_out),
        .frame_done  (frame_done),
        .frozen      (frozen)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expected write per DUT write, checks frame_done latency.
    always @(negedge clk) begin
        wr_t e;
        if (ntsc_in_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h want no write", ntsc_in_addr, pixel_out);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ntsc_in_addr), 32'(e.addr));
                chk("wr_data", 32'(pixel_out), 32'(e.data));
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            chk("done_lat", 32'(prev_wr), 32'd1);
        end
        prev_wr = (ntsc_in_wr === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        sof = 1'b0;
        sol = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic do_sof(input logic f);
        sof = 1'b1;
        field = f;
        cyc();
    endtask

    task automatic do_sol();
        sol = 1'b1;
        cyc();
    endtask

    // Drives n pixels of a line; expected writes are every second pixel below 640.
    task automatic line(input int n, input int row, input bit en);
        logic [11:0] d;
        for (int i = 0; i < n; i++) begin
            if (i % 5 == 3) cyc();
            d = 12'(i * 3 + row * 5);
            pixel_valid = 1'b1;
            rgb_in = d;
            if (en && i < 640 && (i % 2) == 0) exp_q.push_back({17'(row * 320 + i / 2), d});
            cyc();
        end
    endtask

    task automatic rows(input int r0, input int r1, input int len, input bit en);
        for (int r = r0; r <= r1; r++) begin
            do_sol();
            line(len, r, en);
        end
    endtask

    initial begin
        reset = 1'b1;
        pixel_valid = 1'b0;
        sol = 1'b0;
        sof = 1'b0;
        field = 1'b0;
        capture_en = 1'b1;
        rgb_in = '0;
        repeat (3) cyc();
        chk("rst_wr", 32'(ntsc_in_wr), 32'd0);
        chk("rst_addr", 32'(ntsc_in_addr), 32'd0);
        chk("rst_pix", 32'(pixel_out), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd1);
        reset = 1'b0;
        cyc();

        // Wrong parity is ignored; correct parity starts capture.
        do_sof(1'b1);
        chk("odd_frozen", 32'(frozen), 32'd1);
        do_sol();
        line(6, 0, 1'b0);
        chk("odd_frozen2", 32'(frozen), 32'd1);
        do_sof(1'b0);
        chk("start_frozen", 32'(frozen), 32'd0);

        // Field A: long line, short line closed by sol, full last line.
        rows(0, 4, 6, 1'b1);
        do_sol();
        line(700, 5, 1'b1);
        do_sol();
        line(300, 6, 1'b1);
        rows(7, 238, 6, 1'b1);
        do_sol();
        line(640, 239, 1'b1);
        repeat (4) cyc();
        chk("doneA", 32'(done_cnt), 32'd1);
        chk("frozenA", 32'(frozen), 32'd1);
        chk("drainA", 32'(exp_q.size()), 32'd0);

        // Field B: capture_en drops mid-field, field still completes.
        do_sof(1'b0);
        rows(0, 100, 6, 1'b1);
        capture_en = 1'b0;
        chk("midB_frozen", 32'(frozen), 32'd0);
        rows(101, 238, 6, 1'b1);
        do_sol();
        line(640, 239, 1'b1);
        repeat (4) cyc();
        chk("doneB", 32'(done_cnt), 32'd2);
        chk("frozenB", 32'(frozen), 32'd1);
        do_sof(1'b0);
        chk("hold_frozen", 32'(frozen), 32'd1);
        do_sol();
        line(6, 0, 1'b0);
        repeat (3) cyc();
        chk("hold_frozen2", 32'(frozen), 32'd1);
        chk("hold_done", 32'(done_cnt), 32'd2);

        // Field C: premature sof at row 120 restarts at address 0, then mid-line reset.
        capture_en = 1'b1;
        do_sof(1'b0);
        rows(0, 119, 6, 1'b1);
        do_sof(1'b0);
        chk("restart_frozen", 32'(frozen), 32'd0);
        rows(0, 1, 6, 1'b1);
        do_sol();
        line(5, 2, 1'b1);
        reset = 1'b1;
        pixel_valid = 1'b1;
        rgb_in = 12'hABC;
        cyc();
        chk("rst2_wr", 32'(ntsc_in_wr), 32'd0);
        chk("rst2_addr", 32'(ntsc_in_addr), 32'd0);
        chk("rst2_pix", 32'(pixel_out), 32'd0);
        chk("rst2_frozen", 32'(frozen), 32'd1);
        reset = 1'b0;
        repeat (4) cyc();
        chk("doneC", 32'(done_cnt), 32'd2);
        chk("drain_end", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ntsc_capture.md
Name: ntsc_capture

Overview:
- Upstream neighbour of the perspective pixel mapper.
- Takes the decoded, RGB-converted NTSC pixel stream and writes one decimated field (320x240, 12-bit RGB) into ntsc_buf. The mapper later reads ntsc_buf through its own address path.
- Provides a freeze/resume handshake so the mapper can hold a stable source frame while it remaps.
- Single clock domain (the video decoder clock); the ntsc_buf write port runs on the same clock.

Parameters:
- H_ACTIVE, 640, active input pixels per line; pixels beyond this on a line are dropped.
- H_DECIM, 2, horizontal decimation; one of every H_DECIM accepted pixels is written.
- BUF_W, 320, buffer row width in pixels; must equal H_ACTIVE/H_DECIM.
- BUF_H, 240, lines captured per field.
- CAPTURE_FIELD, 0, field parity that is captured; the other field is ignored.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_valid  in  1  rgb_in is an active-video pixel this cycle.
- rgb_in  in  12  pixel, {R[3:0],G[3:0],B[3:0]}.
- sol  in  1  one-cycle start-of-line strobe, before the first pixel of the line.
- sof  in  1  one-cycle start-of-field strobe.
- field  in  1  parity of the current field; valid when sof is high.
- capture_en  in  1  mapper permits buffer overwrite; low = freeze request.
- ntsc_in_wr  out  1  ntsc_buf write enable.
- ntsc_in_addr  out  17  ntsc_buf write address, row*BUF_W + col.
- pixel_out  out  12  ntsc_buf write data.
- frame_done  out  1  one-cycle pulse after the last pixel of a field is written.
- frozen  out  1  high while the buffer is guaranteed unwritten.

Behaviour:
- Reset (synchronous, checked every cycle, overrides everything; applies mid-field too):
  - state=IDLE; ntsc_in_wr=0, ntsc_in_addr=0, pixel_out=0, frame_done=0, frozen=1.
  - Internal col, row and decimation phase cleared.
  - A partially written field is abandoned, not resumed.
- States: IDLE, WAIT_LINE, CAPTURE, DONE.
- IDLE: frozen=1. On sof && field==CAPTURE_FIELD && capture_en:
  - go to WAIT_LINE, row=0, frozen<=0.
  - sof with the other parity, or with capture_en=0, is ignored.
- WAIT_LINE: on sol, go to CAPTURE with col=0, phase=0, input pixel count=0.
- CAPTURE: each pixel_valid increments the input count.
  - While count<H_ACTIVE and phase==0, the pixel is written. Next cycle: ntsc_in_wr=1, pixel_out=rgb_in, ntsc_in_addr=row*BUF_W+col. Then col++.
  - phase advances modulo H_DECIM on every valid pixel.
  - Fixed latency: exactly 1 cycle from accepted pixel to write. ntsc_in_wr is low in every cycle without a write.
  - Address is computed incrementally (running base register += BUF_W per row); no multiplier.
- Line end: the next sol, or reaching col==BUF_W.
  - row++. If row reaches BUF_H, go to DONE; otherwise go to WAIT_LINE.
  - An sol arriving while in CAPTURE closes the current line and opens the next one in the same cycle.
  - Short lines leave unwritten columns with stale data; they are not padded.
- Premature sof during capture (row<BUF_H):
  - Abandon the field; no frame_done.
  - Re-enter the IDLE evaluation in the same cycle (may restart immediately if parity and capture_en allow).
- DONE: frame_done=1 for exactly one cycle, then go to IDLE, frozen<=1.
  - The next eligible sof starts a new capture if capture_en is high.
- capture_en falling mid-field: the current field completes normally; capture stops after DONE.
- capture_en toggling never corrupts an in-progress field.
- frozen: 1 in IDLE and DONE, 0 in WAIT_LINE and CAPTURE. The mapper may read ntsc_buf safely whenever frozen=1 and capture_en=0.
- Address range: 0..BUF_W*BUF_H-1 (0..76799); never exceeds it.
- Widths: col 9 bits, row 8 bits, input count 10 bits, address 17 bits unsigned.

Decomposition:
- Shared package (video_pkg):
  - BUF_W, BUF_H, H_ACTIVE constants.
  - State encoding constants IDLE/WAIT_LINE/CAPTURE/DONE (2 bits).
  - RGB12 width constant.
- One sub-module, capture_addr_gen: holds the row base/col counters and produces ntsc_in_addr, with inc_col, next_row and clear inputs.
- The FSM stays in ntsc_capture.

Test Plan:
- Reset, then sof field=0, capture_en=1, then 240 lines of 640 valid pixels with rgb_in=col index -> 76800 writes, addresses 0..76799 in order. Data at addr k equals input pixel 2*(k mod 320). frame_done pulses once, 1 cycle after the last write. frozen=1 afterwards.
- sof with field=1 -> no writes, frozen stays 1. A following sof with field=0 -> capture starts.
- capture_en driven low after row 100 -> field finishes (frame_done pulses). Next eligible sof -> no writes, frozen=1 held.
- Line with 700 valid pixels -> exactly 320 writes for that row; pixels 640..699 dropped. Line with 300 pixels, then sol -> 150 writes, next row base = previous base + 320.
- sof arrives at row 120 -> no frame_done. If eligible, the new capture restarts at addr 0.
- reset asserted mid-line -> next cycle ntsc_in_wr=0, ntsc_in_addr=0, frozen=1, state IDLE.
